// File: rtl/param_data_path_pkg.sv
// Shared types for the LC-3b style datapath: control bundle, memory FSM
// states, bus gate indices and the ALU / condition-code types.
package lc3b_types;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_PASS = 2'd3
  } lc3b_aluop;

  typedef logic [2:0] lc3b_nzp;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2
  } mem_state_t;

  // Bit positions inside ctl.gate
  localparam int GATE_PC     = 0;
  localparam int GATE_MDR    = 1;
  localparam int GATE_ALU    = 2;
  localparam int GATE_MARMUX = 3;

  typedef struct packed {
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_ben;
    logic [3:0] gate;       // {MARMUX, ALU, MDR, PC}
    logic [1:0] pc_sel;     // 0 bus, 1 PC+1, 2 address adder, 3 zero
    lc3b_aluop  aluk;
    logic       sr1_sel;    // 0 ir[8:6], 1 ir[11:9]
    logic       sr2_sel;    // 0 SR2, 1 sext ir[4:0]
    logic       addr1_sel;  // 0 PC, 1 SR1
    logic [1:0] addr2_sel;  // 0 zero, 1 ir[5:0], 2 ir[8:0], 3 ir[10:0]
    logic       dr_sel;     // 0 ir[11:9], 1 top register
    logic       mem_rd;
    logic       mem_wr;
  } dp_ctl_t;

endpackage

// File: rtl/param_data_path_mem_ctrl.sv
// Memory handshake FSM: IDLE -> RD/WR on request, back to IDLE after ack.
// mem_req/mem_we are decoded from state, so an async reset drops them at once.
module dp_mem_ctrl
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_we,
  output logic busy,
  output logic rd_done
);

  mem_state_t state, state_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_nxt;
  end

  // Next state and Moore outputs; write wins when both requests arrive together
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rd_done   = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (mem_wr)      state_nxt = MEM_WR;
        else if (mem_rd) state_nxt = MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          rd_done   = 1'b1;
          state_nxt = MEM_IDLE;
        end
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_nxt = MEM_IDLE;
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  assign busy = (state != MEM_IDLE);

endmodule

// File: rtl/param_data_path.sv
// Parameterised LC-3b style datapath: shared bus, PC, IR, MAR, MDR,
// register file, ALU, address adder, condition codes and branch enable.
// Optional build macro DP_BUS_CHECK_EN adds a sticky multi-driver bus flag.
module param_data_path
  import lc3b_types::*;
#(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  dp_ctl_t           ctl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic [WIDTH-1:0]  ir,
  output lc3b_nzp           nzp,
  output logic              ben,
  output logic              bus_err
);

  localparam int RA_W = $clog2(NREGS);

  logic [WIDTH-1:0]  pc, mdr, bus, alu_out, alu_b, addr1, addr2, addr_sum, sr1, sr2;
  logic [WIDTH-1:0]  rf [NREGS];
  logic [ADDR_W-1:0] mar;
  logic [RA_W-1:0]   sr1_idx, sr2_idx, dr_idx;
  logic              rd_done;

  function automatic lc3b_nzp cc_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])   return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  assign sr1_idx  = ctl.sr1_sel ? RA_W'(ir[11:9]) : RA_W'(ir[8:6]);
  assign sr2_idx  = RA_W'(ir[2:0]);
  assign dr_idx   = ctl.dr_sel ? RA_W'(NREGS - 1) : RA_W'(ir[11:9]);
  assign sr1      = rf[sr1_idx];
  assign sr2      = rf[sr2_idx];
  assign mem_addr = mar;
  assign mem_wdata = mdr;

  // ALU and address adder; offsets are sign-extended IR fields, carries dropped
  always_comb begin
    alu_b = ctl.sr2_sel ? WIDTH'($signed(ir[4:0])) : sr2;
    alu_out = sr1;
    case (ctl.aluk)
      ALU_ADD:  alu_out = sr1 + alu_b;
      ALU_AND:  alu_out = sr1 & alu_b;
      ALU_NOT:  alu_out = ~sr1;
      ALU_PASS: alu_out = sr1;
      default:  alu_out = sr1;
    endcase
    addr1 = ctl.addr1_sel ? sr1 : pc;
    case (ctl.addr2_sel)
      2'd0:    addr2 = '0;
      2'd1:    addr2 = WIDTH'($signed(ir[5:0]));
      2'd2:    addr2 = WIDTH'($signed(ir[8:0]));
      default: addr2 = WIDTH'($signed(ir[10:0]));
    endcase
    addr_sum = addr1 + addr2;
  end

  // Bus mux: fixed priority PC > MDR > ALU > MARMUX, idle bus reads zero
  always_comb begin
    bus = '0;
    if (ctl.gate[GATE_PC])          bus = pc;
    else if (ctl.gate[GATE_MDR])    bus = mdr;
    else if (ctl.gate[GATE_ALU])    bus = alu_out;
    else if (ctl.gate[GATE_MARMUX]) bus = addr_sum;
  end

  dp_mem_ctrl u_mem_ctrl (
    .clk     (Clk),
    .rst_n   (Reset),
    .mem_rd  (ctl.mem_rd),
    .mem_wr  (ctl.mem_wr),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .busy    (mem_busy),
    .rd_done (rd_done)
  );

  // Architectural registers; read data from memory takes precedence over ld_mdr
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      nzp <= 3'b010;
      ben <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (ctl.ld_pc) begin
        case (ctl.pc_sel)
          2'd0:    pc <= bus;
          2'd1:    pc <= pc + 1'b1;
          2'd2:    pc <= addr_sum;
          default: pc <= '0;
        endcase
      end
      if (ctl.ld_ir)  ir  <= bus;
      if (ctl.ld_mar) mar <= ADDR_W'(bus);
      if (rd_done)         mdr <= mem_rdata;
      else if (ctl.ld_mdr) mdr <= bus;
      if (ctl.ld_reg) rf[dr_idx] <= bus;
      if (ctl.ld_cc)  nzp <= cc_of(bus);
      if (ctl.ld_ben) ben <= |(ir[11:9] & nzp);
    end
  end

`ifdef DP_BUS_CHECK_EN
  // Sticky flag: more than one gate bit in any cycle
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                bus_err <= 1'b0;
    else if ((ctl.gate & (ctl.gate - 4'd1)) != 4'd0) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_data_path.sv
// Directed bench for param_data_path (default 16-bit instance plus a
// 32-bit / 16-register instance for the wide register-file case).
module tb_param_data_path;
  import lc3b_types::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  dp_ctl_t     ctl, ctl32;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata, ir;
  logic        mem_req, mem_we, mem_ack, mem_busy, ben, bus_err;
  logic [2:0]  nzp;

  logic [31:0] mem_addr32, mem_wdata32, mem_rdata32, ir32;
  logic        mem_req32, mem_we32, mem_ack32, mem_busy32, ben32, bus_err32;
  logic [2:0]  nzp32;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_err;

  param_data_path u_dut (
    .Clk(Clk), .Reset(Reset), .ctl(ctl), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .mem_busy(mem_busy), .ir(ir), .nzp(nzp), .ben(ben), .bus_err(bus_err)
  );

  param_data_path #(.WIDTH(32), .NREGS(16), .ADDR_W(32)) u_dut32 (
    .Clk(Clk), .Reset(Reset), .ctl(ctl32), .mem_addr(mem_addr32), .mem_wdata(mem_wdata32),
    .mem_rdata(mem_rdata32), .mem_req(mem_req32), .mem_we(mem_we32), .mem_ack(mem_ack32),
    .mem_busy(mem_busy32), .ir(ir32), .nzp(nzp32), .ben(ben32), .bus_err(bus_err32)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Put a value into MDR through a one-cycle-latency memory read
  task automatic mdr_load(input logic [15:0] v);
    ctl = '0; ctl.mem_rd = 1'b1;
    step();
    ctl = '0; mem_rdata = v; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    mdr_load(v);
    ctl = '0; ctl.gate[GATE_MDR] = 1'b1; ctl.ld_ir = 1'b1;
    step();
    ctl = '0;
  endtask

  task automatic load_pc(input logic [15:0] v);
    mdr_load(v);
    ctl = '0; ctl.gate[GATE_MDR] = 1'b1; ctl.ld_pc = 1'b1; ctl.pc_sel = 2'd0;
    step();
    ctl = '0;
  endtask

  task automatic pc_to_mar();
    ctl = '0; ctl.gate[GATE_PC] = 1'b1; ctl.ld_mar = 1'b1;
    step();
    ctl = '0;
  endtask

  task automatic pc_op(input logic [1:0] sel);
    ctl = '0; ctl.ld_pc = 1'b1; ctl.pc_sel = sel;
    step();
    ctl = '0;
  endtask

  task automatic test_reset();
    n_cmp++; if (ir !== 16'h0000) begin n_bad++; $display("FAIL rst_ir got=%h exp=%h", ir, 16'h0000); end
    n_cmp++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL rst_nzp got=%b exp=%b", nzp, 3'b010); end
    n_cmp++; if ({ben, bus_err, mem_req, mem_we, mem_busy} !== 5'b0) begin
      n_bad++; $display("FAIL rst_flags got=%b exp=%b", {ben, bus_err, mem_req, mem_we, mem_busy}, 5'b0); end
    n_cmp++; if (mem_addr !== 20'h0 || mem_wdata !== 16'h0) begin
      n_bad++; $display("FAIL rst_mar_mdr got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    Reset = 1'b1;
    step();
    load_pc(16'h0042);
    load_pc(16'h0000);
    pc_to_mar();
    n_cmp++; if (mem_addr !== 20'h00000) begin n_bad++; $display("FAIL rst_pc got=%h exp=%h", mem_addr, 20'h0); end
  endtask

  task automatic test_pc();
    load_pc(16'hFFFF);
    pc_to_mar();
    n_cmp++; if (mem_addr !== 20'h0FFFF) begin n_bad++; $display("FAIL pc_bus_zext got=%h exp=%h", mem_addr, 20'h0FFFF); end
    pc_op(2'd1);
    pc_to_mar();
    n_cmp++; if (mem_addr !== 20'h00000) begin n_bad++; $display("FAIL pc_wrap got=%h exp=%h", mem_addr, 20'h0); end
    pc_op(2'd1);
    pc_to_mar();
    n_cmp++; if (mem_addr !== 20'h00001) begin n_bad++; $display("FAIL pc_inc got=%h exp=%h", mem_addr, 20'h1); end
    pc_op(2'd3);
    pc_to_mar();
    n_cmp++; if (mem_addr !== 20'h00000) begin n_bad++; $display("FAIL pc_zero got=%h exp=%h", mem_addr, 20'h0); end
    load_ir(16'h01FE);
    load_pc(16'h0005);
    ctl = '0; ctl.ld_pc = 1'b1; ctl.pc_sel = 2'd2; ctl.addr1_sel = 1'b0; ctl.addr2_sel = 2'd2;
    step();
    pc_to_mar();
    n_cmp++; if (mem_addr !== 20'h00003) begin n_bad++; $display("FAIL pc_adder got=%h exp=%h", mem_addr, 20'h3); end
    load_ir(16'h0400);
    ctl = '0; ctl.gate[GATE_MARMUX] = 1'b1; ctl.ld_mar = 1'b1; ctl.addr2_sel = 2'd3;
    step();
    ctl = '0;
    n_cmp++; if (mem_addr !== 20'h0FC03) begin n_bad++; $display("FAIL marmux_off11 got=%h exp=%h", mem_addr, 20'h0FC03); end
  endtask

  task automatic test_alu_cc();
    load_ir(16'h0400);
    mdr_load(16'h8000);
    ctl = '0; ctl.gate[GATE_MDR] = 1'b1; ctl.ld_reg = 1'b1;
    step();
    load_ir(16'h12BF);
    n_cmp++; if (ir !== 16'h12BF) begin n_bad++; $display("FAIL ir_load got=%h exp=%h", ir, 16'h12BF); end
    ctl = '0; ctl.aluk = ALU_ADD; ctl.sr2_sel = 1'b1; ctl.gate[GATE_ALU] = 1'b1;
    ctl.ld_reg = 1'b1; ctl.ld_cc = 1'b1;
    step();
    n_cmp++; if (nzp !== 3'b001) begin n_bad++; $display("FAIL add_cc got=%b exp=%b", nzp, 3'b001); end
    ctl = '0; ctl.aluk = ALU_PASS; ctl.sr1_sel = 1'b1; ctl.gate[GATE_ALU] = 1'b1; ctl.ld_mdr = 1'b1;
    step();
    n_cmp++; if (mem_wdata !== 16'h7FFF) begin n_bad++; $display("FAIL add_r1 got=%h exp=%h", mem_wdata, 16'h7FFF); end
    ctl = '0; ctl.ld_ben = 1'b1;
    step();
    n_cmp++; if (ben !== 1'b1) begin n_bad++; $display("FAIL ben_set got=%b exp=%b", ben, 1'b1); end
    ctl = '0; ctl.aluk = ALU_NOT; ctl.sr1_sel = 1'b1; ctl.gate[GATE_ALU] = 1'b1; ctl.ld_cc = 1'b1;
    step();
    n_cmp++; if (nzp !== 3'b100) begin n_bad++; $display("FAIL not_cc got=%b exp=%b", nzp, 3'b100); end
    ctl = '0; ctl.ld_ben = 1'b1;
    step();
    n_cmp++; if (ben !== 1'b0) begin n_bad++; $display("FAIL ben_clr got=%b exp=%b", ben, 1'b0); end
    ctl = '0; ctl.ld_cc = 1'b1;
    step();
    ctl = '0;
    n_cmp++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL zero_cc got=%b exp=%b", nzp, 3'b010); end
  endtask

  task automatic test_mem_read();
    mdr_load(16'h0030);
    ctl = '0; ctl.gate[GATE_MDR] = 1'b1; ctl.ld_mar = 1'b1;
    step();
    n_cmp++; if (mem_addr !== 20'h00030) begin n_bad++; $display("FAIL rd_mar got=%h exp=%h", mem_addr, 20'h30); end
    ctl = '0; ctl.mem_rd = 1'b1;
    step();
    ctl = '0;
    n_cmp++; if ({mem_req, mem_we, mem_busy} !== 3'b101) begin
      n_bad++; $display("FAIL rd_c1 got=%b exp=%b", {mem_req, mem_we, mem_busy}, 3'b101); end
    step();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rd_c2 got=%b exp=1", mem_req); end
    step();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rd_c3 got=%b exp=1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    ctl.gate[GATE_PC] = 1'b1; ctl.ld_mdr = 1'b1;
    step();
    mem_ack = 1'b0; mem_rdata = '0; ctl = '0;
    n_cmp++; if ({mem_req, mem_busy} !== 2'b00) begin
      n_bad++; $display("FAIL rd_done got=%b exp=%b", {mem_req, mem_busy}, 2'b00); end
    n_cmp++; if (mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL rd_mdr got=%h exp=%h", mem_wdata, 16'hBEEF); end
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    n_cmp++; if (mem_wdata !== 16'hBEEF || mem_busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack got=%h/%b exp=%h/0", mem_wdata, mem_busy, 16'hBEEF); end
    ctl = '0; ctl.mem_rd = 1'b1; ctl.mem_wr = 1'b1;
    step();
    n_cmp++; if ({mem_req, mem_we} !== 2'b11) begin
      n_bad++; $display("FAIL both_wr got=%b exp=%b", {mem_req, mem_we}, 2'b11); end
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    step();
    mem_ack = 1'b0; mem_rdata = '0; ctl = '0;
    n_cmp++; if (mem_busy !== 1'b0 || mem_wdata !== 16'hBEEF) begin
      n_bad++; $display("FAIL wr_done got=%b/%h exp=0/%h", mem_busy, mem_wdata, 16'hBEEF); end
  endtask

  task automatic test_reset_abort();
    ctl = '0; ctl.mem_wr = 1'b1;
    step();
    ctl = '0;
    n_cmp++; if ({mem_req, mem_we} !== 2'b11) begin
      n_bad++; $display("FAIL wr_start got=%b exp=%b", {mem_req, mem_we}, 2'b11); end
    #2 Reset = 1'b0;
    #1;
    n_cmp++; if ({mem_req, mem_we, mem_busy} !== 3'b000) begin
      n_bad++; $display("FAIL abort_now got=%b exp=%b", {mem_req, mem_we, mem_busy}, 3'b000); end
    #1 Reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    n_cmp++; if (mem_wdata !== 16'h0000 || {mem_req, mem_busy} !== 2'b00) begin
      n_bad++; $display("FAIL late_ack got=%h/%b exp=0000/00", mem_wdata, {mem_req, mem_busy}); end
    n_cmp++; if (nzp !== 3'b010 || ir !== 16'h0) begin
      n_bad++; $display("FAIL abort_regs got=%b/%h exp=010/0000", nzp, ir); end
  endtask

  task automatic test_bus_prio();
`ifdef DP_BUS_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    pc_op(2'd1);
    mdr_load(16'h00A5);
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL err_pre got=%b exp=0", bus_err); end
    ctl = '0; ctl.aluk = ALU_NOT; ctl.gate = 4'b0101; ctl.ld_ir = 1'b1;
    step();
    ctl = '0;
    n_cmp++; if (ir !== 16'h0001) begin n_bad++; $display("FAIL prio_pc got=%h exp=%h", ir, 16'h0001); end
    n_cmp++; if (bus_err !== exp_err) begin n_bad++; $display("FAIL bus_err got=%b exp=%b", bus_err, exp_err); end
    step();
    n_cmp++; if (bus_err !== exp_err) begin n_bad++; $display("FAIL err_sticky got=%b exp=%b", bus_err, exp_err); end
    ctl = '0; ctl.aluk = ALU_NOT; ctl.gate = 4'b0110; ctl.ld_ir = 1'b1;
    step();
    n_cmp++; if (ir !== 16'h00A5) begin n_bad++; $display("FAIL prio_mdr got=%h exp=%h", ir, 16'h00A5); end
    ctl = '0; ctl.aluk = ALU_NOT; ctl.gate = 4'b1100; ctl.ld_ir = 1'b1;
    step();
    n_cmp++; if (ir !== 16'hFFFF) begin n_bad++; $display("FAIL prio_alu got=%h exp=%h", ir, 16'hFFFF); end
    ctl = '0; ctl.ld_ir = 1'b1;
    step();
    ctl = '0;
    n_cmp++; if (ir !== 16'h0000) begin n_bad++; $display("FAIL bus_idle got=%h exp=%h", ir, 16'h0000); end
  endtask

  task automatic test_wide();
    ctl32 = '0; ctl32.mem_rd = 1'b1;
    step();
    ctl32 = '0; mem_rdata32 = 32'h12345678; mem_ack32 = 1'b1;
    step();
    mem_ack32 = 1'b0; mem_rdata32 = '0;
    ctl32 = '0; ctl32.gate[GATE_MDR] = 1'b1; ctl32.ld_reg = 1'b1; ctl32.dr_sel = 1'b1;
    step();
    ctl32 = '0;
    n_cmp++; if (u_dut32.rf[15] !== 32'h12345678) begin
      n_bad++; $display("FAIL wide_r15 got=%h exp=%h", u_dut32.rf[15], 32'h12345678); end
    n_cmp++; if (u_dut32.rf[0] !== 32'h0) begin n_bad++; $display("FAIL wide_r0 got=%h exp=0", u_dut32.rf[0]); end
    n_cmp++; if (mem_wdata32 !== 32'h12345678) begin
      n_bad++; $display("FAIL wide_mdr got=%h exp=%h", mem_wdata32, 32'h12345678); end
    n_cmp++; if ({mem_req32, mem_we32, mem_busy32, bus_err32, ben32} !== 5'b0 || mem_addr32 !== 32'h0
                 || ir32 !== 32'h0 || nzp32 !== 3'b010) begin
      n_bad++; $display("FAIL wide_idle got=%b/%h/%h/%b exp=0/0/0/010",
                        {mem_req32, mem_we32, mem_busy32, bus_err32, ben32}, mem_addr32, ir32, nzp32); end
  endtask

  initial begin
    Reset = 1'b0;
    ctl = '0; ctl32 = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    mem_ack32 = 1'b0; mem_rdata32 = '0;
    repeat (2) step();
    test_reset();
    test_pc();
    test_alu_cc();
    test_mem_read();
    test_reset_abort();
    test_bus_prio();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_data_path.md
PARAM_DATA_PATH -- requirements
Module: param_data_path

Interface
REQ-001 SHALL have parameter WIDTH, 16, datapath/bus/register width (>=12).
REQ-002 SHALL have parameter NREGS, 8, register-file depth (power of two, >=2).
REQ-003 SHALL have parameter ADDR_W, 20, memory address width (>=WIDTH).
REQ-004 SHALL have port Clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ctl  in  dp_ctl_t  control bundle: loads (ir, pc, mar, mdr, reg, cc, ben), gate[3:0] {MARMUX, ALU, MDR, PC}, pc_sel[1:0], aluk, sr1_sel, sr2_sel, addr1_sel, addr2_sel[1:0], dr_sel, mem_rd, mem_wr.
REQ-007 SHALL have port mem_addr  out  ADDR_W  registered MAR value.
REQ-008 SHALL have port mem_wdata  out  WIDTH  MDR value.
REQ-009 SHALL have port mem_rdata  in  WIDTH  read data, valid with mem_ack.
REQ-010 SHALL have port mem_req  out  1  memory request, held until ack.
REQ-011 SHALL have port mem_we  out  1  write qualifier for mem_req.
REQ-012 SHALL have port mem_ack  in  1  single-cycle completion.
REQ-013 SHALL have port mem_busy  out  1  memory FSM not IDLE.
REQ-014 SHALL have port ir  out  WIDTH  instruction register; opcode = ir[WIDTH-1:WIDTH-4].
REQ-015 SHALL have port nzp  out  3  condition-code register.
REQ-016 SHALL have port ben  out  1  registered branch-enable.
REQ-017 SHALL have port bus_err  out  1  sticky multi-driver flag.

Function
REQ-018 Bus SHALL be combinational: priority PC > MDR > ALU > MARMUX over asserted gate bits; no bit -> 0.
REQ-019 ld_pc SHALL load pc_sel: 0 bus, 1 PC+1 (all-ones wraps to 0), 2 address adder, 3 zero.
REQ-020 Address adder SHALL sum addr1 (PC or SR1) and addr2 (0, sext ir[5:0], sext ir[8:0], sext ir[10:0]) modulo 2^WIDTH.
REQ-021 ld_mar SHALL load bus zero-extended to ADDR_W; ld_ir SHALL load bus.
REQ-022 Register file: NREGS x WIDTH, async read (SR1 = ir[8:6] or ir[11:9] per sr1_sel; SR2 = ir[2:0]); ld_reg writes bus to ir[11:9], or NREGS-1 when dr_sel=1; same-cycle read returns old value.
REQ-023 ALU SHALL implement lc3b_aluop ADD/AND/NOT/PASS on SR1 and (SR2 or sext ir[4:0] per sr2_sel), result WIDTH bits, carry discarded.
REQ-024 ld_cc SHALL latch nzp from bus sign/zero: exactly one bit set.
REQ-025 ld_ben SHALL latch ben = |(ir[11:9] & nzp) using current nzp.
REQ-026 Memory FSM states IDLE, RD, WR; IDLE + mem_wr -> WR; IDLE + mem_rd (no mem_wr) -> RD; both -> WR.
REQ-027 In RD/WR mem_req=1 (mem_we=1 in WR); on mem_ack return to IDLE next cycle; mem_req drops in that same next cycle; one-cycle minimum latency to ack.
REQ-028 RD + mem_ack SHALL load mem_rdata into MDR; concurrent ld_mdr ignored; otherwise ld_mdr loads bus.
REQ-029 mem_rd/mem_wr outside IDLE and mem_ack in IDLE SHALL be ignored.

Reset
REQ-030 Reset low SHALL immediately force PC, IR, MAR, MDR, registers to 0, nzp=3'b010, ben=0, bus_err=0, FSM IDLE, mem_req=0, mem_we=0, including mid-transaction.
REQ-031 A mem_ack arriving after an aborting reset SHALL be ignored.

Configuration
REQ-032 With DP_BUS_CHECK_EN defined, bus_err SHALL set on any cycle with >1 gate bit asserted and hold until reset; undefined, bus_err SHALL be constant 0 and no checker logic exists; bus priority unchanged either way.

Structure
REQ-033 lc3b_types SHALL hold dp_ctl_t, the memory-state enum, gate-index constants; existing lc3b_aluop/lc3b_nzp reused.
REQ-034 Memory FSM SHALL be sub-module dp_mem_ctrl; all else inline.

Verification
REQ-035 PC=16'hFFFF, ld_pc, pc_sel=1 -> PC=16'h0000.
REQ-036 mem_rd with MAR=20'h00030, ack after 3 cycles, mem_rdata=16'hBEEF -> mem_req high 3 cycles, MDR=16'hBEEF, mem_busy low next cycle.
REQ-037 Reset pulse while in WR -> mem_req=0 same cycle; late ack leaves MDR=0, FSM IDLE.
REQ-038 R2=16'h8000, ADD imm5=-1 to R1, ld_cc -> R1=16'h7FFF, nzp=3'b001; ir[11:9]=3'b001, ld_ben -> ben=1.
REQ-039 gate=4'b0101 (PC, ALU) -> bus=PC; bus_err=1 with DP_BUS_CHECK_EN, 0 without.
REQ-040 NREGS=16, WIDTH=32: dr_sel=1, ld_reg, bus=32'h12345678 -> R15=32'h12345678.
